// File: rtl/rv32_scoreboard_if.sv
// rv32_scoreboard_if: decode/issue, writeback, squash and status signals around the scoreboard
interface rv32_scoreboard_if #(parameter int NUM_READ = 2);
  logic                     dec_valid;
  logic [NUM_READ-1:0][4:0] dec_rs;
  logic [NUM_READ-1:0]      dec_use_rs;
  logic [4:0]               dec_rd;
  logic                     dec_register_wb;
  logic                     dec_csr_wb;
  logic                     ex_ready;
  logic                     issue;
  logic                     stall;
  logic                     wb_valid;
  logic [4:0]               wb_rd;
  logic                     sq_valid;
  logic [4:0]               sq_rd;
  logic                     csr_done;
  logic [31:0]              pending_mask;
  logic                     csr_busy;
  logic                     sb_err;
  modport slave (
    input  dec_valid, dec_rs, dec_use_rs, dec_rd, dec_register_wb, dec_csr_wb, ex_ready,
    input  wb_valid, wb_rd, sq_valid, sq_rd, csr_done,
    output issue, stall, pending_mask, csr_busy, sb_err
  );
  modport master (
    output dec_valid, dec_rs, dec_use_rs, dec_rd, dec_register_wb, dec_csr_wb, ex_ready,
    output wb_valid, wb_rd, sq_valid, sq_rd, csr_done,
    input  issue, stall, pending_mask, csr_busy, sb_err
  );
endinterface

// File: rtl/rv32_scoreboard.sv
// rv32_scoreboard: per-register in-flight write tracking, RAW/saturation/Zicsr issue gating; RV32_SB_WB_FWD_EN lets same-cycle retires clear hazards
module rv32_scoreboard #(
  parameter int NUM_READ     = 2,
  parameter int MAX_INFLIGHT = 3
) (
  input logic              clk,
  input logic              rstn,
  rv32_scoreboard_if.slave sb
);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  logic [CW-1:0] cnt [32];
  logic [CW-1:0] nxt [32];
  logic [31:0]   under;
  logic [31:0]   pend;
  logic          hazard, sat, csr_block, blocked, csr_busy, sb_err;
  // x0 never holds a count, so its pending bit stays 0
  always_comb begin
    pend = '0;
    for (int r = 1; r < 32; r++) pend[r] = |cnt[r];
  end
  // a source hazards only while its effective in-flight count is nonzero
  always_comb begin
`ifdef RV32_SB_WB_FWD_EN
    int e;
    e = 0;
`endif
    hazard = 1'b0;
    for (int i = 0; i < NUM_READ; i++) begin
`ifdef RV32_SB_WB_FWD_EN
      e = int'(cnt[sb.dec_rs[i]]) - int'(sb.wb_valid && sb.wb_rd == sb.dec_rs[i])
        - int'(sb.sq_valid && sb.sq_rd == sb.dec_rs[i]);
      hazard = hazard | (sb.dec_use_rs[i] && sb.dec_rs[i] != 5'd0 && e > 0);
`else
      hazard = hazard | (sb.dec_use_rs[i] && sb.dec_rs[i] != 5'd0 && cnt[sb.dec_rs[i]] != '0);
`endif
    end
  end
  assign sat             = sb.dec_register_wb && cnt[sb.dec_rd] == CW'(MAX_INFLIGHT);
  assign csr_block       = sb.dec_csr_wb && |pend;
  assign blocked         = hazard || csr_busy || sat || csr_block;
  assign sb.issue        = sb.dec_valid && sb.ex_ready && !blocked;
  assign sb.stall        = sb.dec_valid && blocked;
  assign sb.pending_mask = pend;
  assign sb.csr_busy     = csr_busy;
  assign sb.sb_err       = sb_err;
  // net per-register update: +issue -writeback -squash, clamped at zero on underflow
  always_comb begin
    int n;
    n = 0;
    nxt[0] = '0;
    under = '0;
    for (int r = 1; r < 32; r++) begin
      n = int'(cnt[r]) + int'(sb.issue && sb.dec_register_wb && sb.dec_rd == 5'(r))
        - int'(sb.wb_valid && sb.wb_rd == 5'(r)) - int'(sb.sq_valid && sb.sq_rd == 5'(r));
      under[r] = n < 0;
      nxt[r] = n < 0 ? '0 : CW'(n);
    end
  end
  // counters, Zicsr busy flag (issue beats done) and sticky underflow error
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < 32; r++) cnt[r] <= '0;
      csr_busy <= 1'b0;
      sb_err <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) cnt[r] <= nxt[r];
      csr_busy <= (sb.issue && sb.dec_csr_wb) ? 1'b1 : sb.csr_done ? 1'b0 : csr_busy;
      sb_err <= sb_err | (|under);
    end
  end
endmodule
